hilo_muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer that owns the architectural HI/LO registers.
- Sits beside EX. Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO, runs one iteration per cycle, then commits HI/LO.
- Stalls the front end while a result is pending and ID needs it (MFHI/MFLO), or when a new HI/LO op arrives.
- HI/LO outputs feed the MEM/WB pipeline register's HI/LO path.

---
 rtl/hilo_muldiv_ctrl_if.sv | 31 +++
 rtl/hilo_muldiv_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_ctrl_if.sv
// Handshake bundle between EX/ID and the HI/LO multiply/divide sequencer.
// The master side is the pipeline; the slave side is the sequencer.
interface hilo_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OpA;
   logic [WIDTH-1:0] OpB;
   logic             WriteHi;
   logic             WriteLo;
   logic [WIDTH-1:0] WData;
   logic             ReadHiLo;
   logic             Flush;
   logic             Busy;
   logic             Stall;
   logic             Done;
   logic             DivZero;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output Start, Op, OpA, OpB, WriteHi, WriteLo, WData, ReadHiLo, Flush,
      input  Busy, Stall, Done, DivZero, HI, LO
   );

   modport slave (
      input  Start, Op, OpA, OpB, WriteHi, WriteLo, WData, ReadHiLo, Flush,
      output Busy, Stall, Done, DivZero, HI, LO
   );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle, sign fix-up and commit in FIN.
module hilo_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input logic              Clk,
   input logic              Reset,
   hilo_muldiv_ctrl_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opd_q, opd_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_lo_q, neg_lo_d;
   logic                 neg_hi_q, neg_hi_d;
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 done_q, done_d;
   logic                 divzero_q, divzero_d;

   logic                 signed_op;
   logic                 sign_a;
   logic                 sign_b;
   logic [WIDTH-1:0]     mag_a;
   logic [WIDTH-1:0]     mag_b;
   logic [2*WIDTH-1:0]   prod;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   // acc = {partial product, remaining multiplier bits}; add on LSB, then shift right.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   mcand);
      logic [WIDTH:0] sum;
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
      return {sum, acc[WIDTH-1:1]};
   endfunction

   // acc = {partial remainder, dividend bits / quotient bits}; shift left, trial subtract.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0]   dvsr);
      logic [WIDTH:0]   shifted;
      logic [WIDTH-1:0] rem_new;
      logic             qbit;
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      qbit    = (shifted >= {1'b0, dvsr});
      rem_new = qbit ? WIDTH'(shifted - {1'b0, dvsr}) : shifted[WIDTH-1:0];
      return {rem_new, acc[WIDTH-2:0], qbit};
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opd_d     = opd_q;
      is_div_d  = is_div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;
      signed_op = ~bus.Op[0];
      sign_a    = signed_op & bus.OpA[WIDTH-1];
      sign_b    = signed_op & bus.OpB[WIDTH-1];
      mag_a     = cond_neg(bus.OpA, sign_a);
      mag_b     = cond_neg(bus.OpB, sign_b);
      prod      = cond_neg2(acc_q, neg_lo_q);

      unique case (state_q)
         IDLE: begin
            if (!bus.Flush) begin
               if (bus.Start) begin
                  is_div_d = bus.Op[1];
                  neg_lo_d = sign_a ^ sign_b;
                  neg_hi_d = sign_a;
                  dz_d     = bus.Op[1] && (bus.OpB == '0);
                  // A zero divisor keeps the raw dividend so the remainder ends up as OpA.
                  if (bus.Op[1]) begin
                     acc_d = {{WIDTH{1'b0}}, (dz_d ? bus.OpA : mag_a)};
                     opd_d = mag_b;
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, mag_b};
                     opd_d = mag_a;
                  end
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  if (bus.WriteHi) hi_d = bus.WData;
                  if (bus.WriteLo) lo_d = bus.WData;
               end
            end
         end
         RUN: begin
            if (bus.Flush) begin
               state_d = IDLE;
            end else begin
               acc_d = is_div_q ? div_step(acc_q, opd_q) : mul_step(acc_q, opd_q);
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
            if (!bus.Flush) begin
               if (!is_div_q) begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (dz_q) begin
                  hi_d = acc_q[2*WIDTH-1:WIDTH];
                  lo_d = acc_q[WIDTH-1:0];
               end else begin
                  hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
                  lo_d = cond_neg(acc_q[WIDTH-1:0], neg_lo_q);
               end
               done_d    = 1'b1;
               divzero_d = dz_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opd_q     <= opd_d;
         is_div_q  <= is_div_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign bus.Busy    = (state_q != IDLE);
   assign bus.Stall   = bus.Busy & (bus.ReadHiLo | bus.Start | bus.WriteHi | bus.WriteLo);
   assign bus.Done    = done_q;
   assign bus.DivZero = divzero_q;
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: reference-model scoreboard plus latency, stall, flush and reset checks.
module tb_hilo_muldiv_ctrl;
   localparam int W = 32;

   logic Clk = 1'b0;
   logic Reset;

   hilo_muldiv_ctrl_if #(.WIDTH(W)) bus();
   hilo_muldiv_ctrl #(.WIDTH(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W:0] sb_q[$];   // {DivZero, HI, LO}

   function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint     sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: begin p = sa * sb; return {1'b0, p}; end
         2'b01: begin p = ua * ub; return {1'b0, p}; end
         default: begin
            if (b == '0) return {1'b1, a, {W{1'b1}}};
            if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {1'b0, r[W-1:0], q[W-1:0]};
            end
            p = ua / ub;
            ub = ua % ub;
            return {1'b0, ub[W-1:0], p[W-1:0]};
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit push);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.OpA   = a;
      bus.OpB   = b;
      if (push) sb_q.push_back(model(op, a, b));
      tick();
      bus.Start = 1'b0;
   endtask

   // Called in the slot right after the Start edge; returns in the Done cycle.
   task automatic finish_op(input string tag);
      int lat  = 0;
      int busy = 0;
      logic [2*W:0] e;
      while (bus.Done !== 1'b1 && lat < 100) begin
         if (bus.Busy === 1'b1) busy++;
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 33);
      check({tag, "_busy_cycles"}, busy, 33);
      check({tag, "_busy_at_done"}, bus.Busy, 0);
      check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
      check({tag, "_hi"}, bus.HI, e[2*W-1:W]);
      check({tag, "_lo"}, bus.LO, e[W-1:0]);
      check({tag, "_divzero"}, bus.DivZero, e[2*W]);
   endtask

   initial begin
      bus.Start = 0; bus.Op = 0; bus.OpA = 0; bus.OpB = 0;
      bus.WriteHi = 0; bus.WriteLo = 0; bus.WData = 0;
      bus.ReadHiLo = 0; bus.Flush = 0;
      Reset = 1'b1;
      tick();
      tick();
      check("rst_hi", bus.HI, 0);
      check("rst_lo", bus.LO, 0);
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_divzero", bus.DivZero, 0);
      check("rst_stall", bus.Stall, 0);
      Reset = 1'b0;
      tick();

      // MULT 7 * -3
      start_op(2'b00, 32'd7, 32'hFFFFFFFD, 1);
      finish_op("mult_neg");
      check("mult_neg_hi_const", bus.HI, 32'hFFFFFFFF);
      check("mult_neg_lo_const", bus.LO, 32'hFFFFFFEB);
      tick();
      check("done_pulse_width", bus.Done, 0);

      // MULTU max*max, then DIV -7/2 back to back in the Done cycle
      start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      finish_op("multu_max");
      check("multu_hi_const", bus.HI, 32'hFFFFFFFE);
      check("multu_lo_const", bus.LO, 32'h00000001);
      start_op(2'b10, 32'hFFFFFFF9, 32'd2, 1);
      finish_op("div_b2b");
      check("div_lo_const", bus.LO, 32'hFFFFFFFD);
      check("div_hi_const", bus.HI, 32'hFFFFFFFF);
      tick();

      // DIVU by zero
      start_op(2'b11, 32'd100, 32'd0, 1);
      finish_op("divu_zero");
      check("divu_zero_done", bus.Done, 1);
      tick();
      check("divzero_pulse_width", bus.DivZero, 0);
      check("divzero_done_clear", bus.Done, 0);

      // Signed DIV by zero keeps raw OpA, overflow case, negative divisor
      start_op(2'b10, 32'hFFFFFF00, 32'd0, 1);
      finish_op("div_zero_neg");
      start_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1);
      finish_op("div_ovf");
      start_op(2'b10, 32'd37, 32'hFFFFFFFA, 1);
      finish_op("div_negb");
      for (int i = 0; i < 4; i++) begin
         start_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 32'hFFFF), 1);
         finish_op("rand_op");
      end

      // Flush on the 10th RUN cycle
      tick();
      bus.WriteHi = 1; bus.WriteLo = 1; bus.WData = 32'h12345678;
      tick();
      bus.WriteHi = 0; bus.WriteLo = 0;
      start_op(2'b00, 32'd1234, 32'd5678, 0);
      for (int i = 0; i < 9; i++) tick();
      check("flush_busy_before", bus.Busy, 1);
      bus.Flush = 1;
      tick();
      bus.Flush = 0;
      check("flush_busy_after", bus.Busy, 0);
      for (int i = 0; i < 40; i++) begin
         if (bus.Done !== 1'b0) check("flush_no_done", bus.Done, 0);
         tick();
      end
      check("flush_hi", bus.HI, 32'h12345678);
      check("flush_lo", bus.LO, 32'h12345678);

      // DIVU with ReadHiLo and a held MTLO
      begin
         int cyc = 0;
         int bad = 0;
         start_op(2'b11, 32'd1000, 32'd7, 0);
         bus.ReadHiLo = 1; bus.WriteLo = 1; bus.WData = 32'hDEAD0000;
         #1;
         while (bus.Done !== 1'b1 && cyc < 100) begin
            if (bus.Stall !== 1'b1 || bus.Busy !== 1'b1) bad++;
            @(posedge Clk); #2;
            cyc++;
         end
         check("stall_bad_cycles", bad, 0);
         check("stall_cycles", cyc, 33);
         check("stall_done_cycle", bus.Stall, 0);
         check("stall_quotient", bus.LO, 32'd142);
         check("stall_remainder", bus.HI, 32'd6);
         tick();
         bus.ReadHiLo = 0; bus.WriteLo = 0;
         check("mtlo_replay_lo", bus.LO, 32'hDEAD0000);
         check("mtlo_replay_hi", bus.HI, 32'd6);
      end

      // Idle MT writes, Start beating MT, Flush blocking idle ops
      bus.WriteHi = 1; bus.WriteLo = 1; bus.WData = 32'hA5A5A5A5;
      tick();
      bus.WriteHi = 0; bus.WriteLo = 0;
      check("mt_hi", bus.HI, 32'hA5A5A5A5);
      check("mt_lo", bus.LO, 32'hA5A5A5A5);
      bus.WriteHi = 1; bus.WData = 32'h11111111;
      bus.Start = 1; bus.Op = 2'b01; bus.OpA = 2; bus.OpB = 3;
      sb_q.push_back(model(2'b01, 2, 3));
      #1;
      check("start_mt_stall", bus.Stall, 0);
      tick();
      bus.Start = 0; bus.WriteHi = 0;
      finish_op("start_wins");
      bus.Flush = 1; bus.Start = 1; bus.WriteHi = 1; bus.WData = 32'h77777777;
      tick();
      bus.Flush = 0; bus.Start = 0; bus.WriteHi = 0;
      check("idle_flush_busy", bus.Busy, 0);
      check("idle_flush_hi", bus.HI, 0);

      // Reset mid-RUN
      start_op(2'b00, 32'd3, 32'd5, 0);
      for (int i = 0; i < 5; i++) tick();
      Reset = 1;
      tick();
      Reset = 0;
      check("midrst_hi", bus.HI, 0);
      check("midrst_lo", bus.LO, 0);
      check("midrst_busy", bus.Busy, 0);
      check("midrst_done", bus.Done, 0);
      for (int i = 0; i < 40; i++) begin
         if (bus.Done !== 1'b0) check("midrst_no_done", bus.Done, 0);
         tick();
      end
      check("final_busy", bus.Busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
